// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module   : dcache_ctrl
//  Brief    : Direct-mapped, write-back, write-allocate byte data cache
//             in front of a 32-bit-block data memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int c_IDX_W = $clog2(NUM_BLOCKS);
    localparam int c_OFF_W = $clog2(BLOCK_BYTES);
    localparam int c_TAG_W = 8 - c_IDX_W - c_OFF_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_UPDATE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_data [NUM_BLOCKS];
    logic [c_TAG_W-1:0]     r_tag  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]  r_valid;
    logic [NUM_BLOCKS-1:0]  r_dirty;
    logic [31:0]            r_fill;
    logic [7:0]             r_rdata;
    logic                   r_seen;

    logic [c_TAG_W-1:0]     w_tag;
    logic [c_IDX_W-1:0]     w_idx;
    logic [c_OFF_W-1:0]     w_off;
    logic [31:0]            w_line;
    logic [7:0]             w_byte;
    logic                   w_hit;
    logic                   w_req;
    logic                   w_done;
    logic                   w_rd_hit;
    logic                   w_wr_hit;

    assign w_tag    = ADDRESS[7 -: c_TAG_W];
    assign w_idx    = ADDRESS[c_OFF_W +: c_IDX_W];
    assign w_off    = ADDRESS[c_OFF_W-1:0];
    assign w_line   = r_data[w_idx];
    assign w_byte   = w_line[{w_off, 3'b000} +: 8];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_req    = READ || WRITE;
    // A transfer is complete once memory has been seen busy and then idle.
    assign w_done   = r_seen && !MEM_BUSYWAIT;
    assign w_rd_hit = (r_state == S_IDLE) && READ && w_hit;
    assign w_wr_hit = (r_state == S_IDLE) && WRITE && w_hit;

    assign BUSYWAIT = RESET && w_req && !((r_state == S_IDLE) && w_hit);
    assign READDATA = w_rd_hit ? w_byte : r_rdata;

    always_comb begin
        w_next        = r_state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {r_tag[w_idx], w_idx};
                MEM_WRITEDATA = w_line;
                if (w_done) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (w_done) begin
                    w_next = S_UPDATE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_seen  <= 1'b0;
            r_valid <= '0;
            r_dirty <= '0;
            r_rdata <= 8'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WRITEBACK) || (r_state == S_FETCH)) begin
                if (w_done) begin
                    r_seen <= 1'b0;
                end else if (MEM_BUSYWAIT) begin
                    r_seen <= 1'b1;
                end
            end else begin
                r_seen <= 1'b0;
            end
            if (r_state == S_UPDATE) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_wr_hit) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_rd_hit) begin
                r_rdata <= w_byte;
            end
        end
    end

    // Line data and tags need no reset; valid bits qualify them.
    always_ff @(posedge CLK) begin
        if ((r_state == S_FETCH) && w_done) begin
            r_fill <= MEM_READDATA;
        end
        if (r_state == S_UPDATE) begin
            r_data[w_idx] <= r_fill;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Brief    : Directed self-checking bench for dcache_ctrl with a behavioural
//             block memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

    localparam int N = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int total = 0;
    int bad   = 0;

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: a transfer occupies N cycles counting the request cycle, and
    // one recovery cycle is required before the next request is accepted.
    logic [31:0] mem [64];
    logic [1:0]  m_st;
    int          m_cnt;
    logic [5:0]  m_addr;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic        m_loaded = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_st         <= 2'd0;
            m_cnt        <= 0;
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= 32'd0;
            if (!m_loaded) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
                mem[6'h00] <= 32'h44332211;
                mem[6'h08] <= 32'h88776655;
                mem[6'h27] <= 32'hDDCCBBAA;
                mem[6'h3F] <= 32'h0F0E0D0C;
                m_loaded   <= 1'b1;
            end
        end else begin
            case (m_st)
                2'd0: if (MEM_READ || MEM_WRITE) begin
                    m_addr       <= MEM_ADDRESS;
                    m_wr         <= MEM_WRITE;
                    m_wdata      <= MEM_WRITEDATA;
                    m_cnt        <= N - 2;
                    MEM_BUSYWAIT <= 1'b1;
                    m_st         <= 2'd1;
                end
                2'd1: if (m_cnt == 0) begin
                    if (m_wr) mem[m_addr] <= m_wdata;
                    else      MEM_READDATA <= mem[m_addr];
                    MEM_BUSYWAIT <= 1'b0;
                    m_st         <= 2'd2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2'd2:    m_st <= 2'd3;
                default: m_st <= 2'd0;
            endcase
        end
    end

    int          n_busy;
    logic [7:0]  rdata;
    logic        saw_mr, saw_mw, mr_first, both, unstable, timed_out;
    logic [5:0]  mr_addr, mw_addr;
    logic [31:0] mw_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access, held until BUSYWAIT drops; records memory-side traffic.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        int guard;
        n_busy = 0; saw_mr = 0; saw_mw = 0; mr_first = 0; both = 0; unstable = 0;
        mr_addr = '0; mw_addr = '0; mw_data = '0;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        guard = 0;
        #1;
        while (BUSYWAIT === 1'b1 && guard < 200) begin
            n_busy++;
            if (MEM_READ && MEM_WRITE) both = 1;
            if (MEM_WRITE === 1'b1) begin
                if (!saw_mw) begin
                    mw_addr = MEM_ADDRESS; mw_data = MEM_WRITEDATA;
                end else if (MEM_ADDRESS !== mw_addr || MEM_WRITEDATA !== mw_data) begin
                    unstable = 1;
                end
                saw_mw = 1;
            end
            if (MEM_READ === 1'b1) begin
                if (!saw_mr) begin
                    mr_addr = MEM_ADDRESS;
                    if (!saw_mw) mr_first = 1;
                end else if (MEM_ADDRESS !== mr_addr) begin
                    unstable = 1;
                end
                saw_mr = 1;
            end
            guard++;
            @(negedge CLK);
            #1;
        end
        timed_out = (guard >= 200);
        rdata = READDATA;
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busywait", 32'(BUSYWAIT), 32'h0);
        chk("rst_mem_read", 32'(MEM_READ), 32'h0);
        chk("rst_mem_write", 32'(MEM_WRITE), 32'h0);
        chk("rst_readdata", 32'(READDATA), 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Clean read miss on index 0
        access(1'b1, 1'b0, 8'h00, 8'h00);
        chk("t1_timeout", 32'(timed_out), 32'h0);
        chk("t1_busy_cycles", 32'(n_busy), 32'd8);
        chk("t1_mem_read", 32'(saw_mr), 32'h1);
        chk("t1_mem_addr", 32'(mr_addr), 32'h00);
        chk("t1_no_mem_write", 32'(saw_mw), 32'h0);
        chk("t1_readdata", 32'(rdata), 32'h11);

        // Read hit, upper byte of the same line
        access(1'b1, 1'b0, 8'h03, 8'h00);
        chk("t2_busy_cycles", 32'(n_busy), 32'd0);
        chk("t2_readdata", 32'(rdata), 32'h44);

        // Write hit then read back
        access(1'b0, 1'b1, 8'h01, 8'hAB);
        chk("t3_write_busy", 32'(n_busy), 32'd0);
        access(1'b1, 1'b0, 8'h01, 8'h00);
        chk("t3_read_busy", 32'(n_busy), 32'd0);
        chk("t3_readdata", 32'(rdata), 32'hAB);
        chk("t3_no_traffic", 32'({saw_mr, saw_mw}), 32'h0);

        // Conflict miss with a dirty victim
        access(1'b1, 1'b0, 8'h20, 8'h00);
        chk("t4_timeout", 32'(timed_out), 32'h0);
        chk("t4_busy_cycles", 32'(n_busy), 32'd15);
        chk("t4_mem_write", 32'(saw_mw), 32'h1);
        chk("t4_wb_addr", 32'(mw_addr), 32'h00);
        chk("t4_wb_data", mw_data, 32'h4433AB11);
        chk("t4_fetch_addr", 32'(mr_addr), 32'h08);
        chk("t4_read_before_wb", 32'(mr_first), 32'h0);
        chk("t4_both_high", 32'(both), 32'h0);
        chk("t4_stable", 32'(unstable), 32'h0);
        chk("t4_readdata", 32'(rdata), 32'h55);
        chk("t4_mem0", mem[0], 32'h4433AB11);

        // Write miss on clean index 7
        access(1'b0, 1'b1, 8'h9E, 8'h45);
        chk("t5_busy_cycles", 32'(n_busy), 32'd8);
        chk("t5_fetch_addr", 32'(mr_addr), 32'h27);
        chk("t5_no_mem_write", 32'(saw_mw), 32'h0);
        access(1'b1, 1'b0, 8'h9E, 8'h00);
        chk("t5_read_busy", 32'(n_busy), 32'd0);
        chk("t5_readdata", 32'(rdata), 32'h45);

        // Evicting index 7 proves it was left dirty by the write miss
        access(1'b1, 1'b0, 8'hFC, 8'h00);
        chk("t6_busy_cycles", 32'(n_busy), 32'd15);
        chk("t6_wb_addr", 32'(mw_addr), 32'h27);
        chk("t6_wb_data", mw_data, 32'hDD45BBAA);
        chk("t6_fetch_addr", 32'(mr_addr), 32'h3F);
        chk("t6_readdata", 32'(rdata), 32'h0C);
        #1;
        chk("t6_readdata_hold", 32'(READDATA), 32'h0C);

        // Reset in the middle of a fetch
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h00;
        @(negedge CLK);
        #1;
        chk("t7_fetch_mem_read", 32'(MEM_READ), 32'h1);
        chk("t7_fetch_busywait", 32'(BUSYWAIT), 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        chk("t7_rst_mem_read", 32'(MEM_READ), 32'h0);
        chk("t7_rst_busywait", 32'(BUSYWAIT), 32'h0);
        chk("t7_rst_readdata", 32'(READDATA), 32'h0);
        @(negedge CLK);
        READ = 1'b0;
        RESET = 1'b1;

        // Valid bits were cleared, so index 0 misses again
        access(1'b1, 1'b0, 8'h01, 8'h00);
        chk("t8_timeout", 32'(timed_out), 32'h0);
        chk("t8_busy_cycles", 32'(n_busy), 32'd8);
        chk("t8_fetch_addr", 32'(mr_addr), 32'h00);
        chk("t8_no_mem_write", 32'(saw_mw), 32'h0);
        chk("t8_readdata", 32'(rdata), 32'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory.
- Serves 8-bit loads and stores.
- Drives BUSYWAIT, which stalls the PC and gates register-file writes while a miss is serviced.
- Load data on READDATA feeds the register-file write port.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width = log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width = 2; fixed, memory side is one 32-bit word.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  CPU load request, held until BUSYWAIT low.
- WRITE  input  1  CPU store request, held until BUSYWAIT low; never asserted together with READ.
- ADDRESS  input  8  byte address: [7:5] tag, [4:2] index, [1:0] offset.
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data.
- BUSYWAIT  output  1  CPU stall.
- MEM_READ  output  1  memory block read request.
- MEM_WRITE  output  1  memory block write request.
- MEM_ADDRESS  output  6  block address {tag,index}.
- MEM_WRITEDATA  output  32  evicted block, byte 0 in [7:0].
- MEM_READDATA  input  32  fetched block, byte 0 in [7:0].
- MEM_BUSYWAIT  input  1  memory busy; high from the cycle after a request until the transfer completes.

Behaviour:
- Storage: per line a 32-bit data word, 3-bit tag, valid bit and dirty bit.
- hit = valid[index] && tag[index]==ADDRESS[7:5]; combinational.
- Reset (RESET low, asynchronous):
  - state=IDLE; all valid and dirty bits cleared; data and tags don't-care.
  - MEM_READ=MEM_WRITE=0, BUSYWAIT=0, READDATA=0.
  - Reset mid-miss aborts the transfer; the memory request drops immediately.
- BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit). Goes high combinationally in the request cycle on a miss.
- Read hit:
  - READDATA = selected byte of the line, combinational; zero-cycle stall.
  - READDATA holds its last value when READ is low.
- Write hit: at the rising edge in IDLE, the selected byte is written and dirty[index]=1. Zero stall.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
  - IDLE: if (READ|WRITE) and miss, go to WRITEBACK when valid&&dirty on the victim line, otherwise go to FETCH.
  - WRITEBACK:
    - Drives MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data.
    - Moves to FETCH at the first rising edge where MEM_BUSYWAIT is sampled low after having been sampled high in this state.
  - FETCH:
    - Drives MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
    - Exits under the same completion rule as WRITEBACK and latches MEM_READDATA.
  - UPDATE (1 cycle): writes data, tag=ADDRESS[7:5], valid=1, dirty=0, then goes to IDLE.
  - Back in IDLE the access is a hit and completes as above. A write miss therefore ends with dirty=1.
- MEM_READ and MEM_WRITE are never high together. Both are low outside their states.
- MEM_ADDRESS and MEM_WRITEDATA are held stable for the whole request.
- Miss latency with memory busy for N cycles: clean miss = N+3 cycles of BUSYWAIT; dirty miss = 2N+5.
- The CPU must hold ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT is high. Changes during a miss are undefined.
- Same-index conflict: a new tag evicts the old line. A dirty victim is always written back before the fetch.

Test Plan:
- Reset then READ ADDRESS=0x00 with memory returning 0x44332211 after N=5 → BUSYWAIT high 8 cycles, MEM_READ with MEM_ADDRESS=0x00, then READDATA=0x11 and no MEM_WRITE.
- READ 0x03 after the previous fill → hit, BUSYWAIT never high, READDATA=0x44 in the same cycle.
- WRITE 0xAB to 0x01 (hit), then READ 0x01 → READDATA=0xAB, dirty[0]=1, no memory traffic.
- READ 0x20 (same index 0, tag 1) → MEM_WRITE first with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0x4433AB11, then MEM_READ with MEM_ADDRESS=0x08, total BUSYWAIT 2N+5=15 cycles.
- WRITE miss 0x45 to 0x9E (index 7 clean) → fetch, then byte 2 written, dirty[7]=1; READ 0x9E returns 0x45.
- RESET low during FETCH → MEM_READ and BUSYWAIT drop immediately. After release, READ 0x00 misses again because valid was cleared.
